// File: rtl/mouse_frame_sync_pkg.sv
// Shared display constants and coordinate type for the mouse/cursor path.
package mouse_frame_sync_pkg;

  localparam int unsigned HOR_ACTIVE = 1024;
  localparam int unsigned VER_ACTIVE = 768;
  localparam int unsigned COORD_W    = 12;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/mouse_frame_sync_if.sv
// Video timing bus as seen by the mouse frame synchroniser.
interface vga_if;

  logic vsync;

  modport master (output vsync);
  modport slave  (input  vsync);
  modport in     (input  vsync);

endinterface

// File: rtl/mouse_frame_sync_rise_detect.sv
// One-bit registered rising-edge detector.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/mouse_frame_sync.sv
// Holds mouse reports as pending and commits them (clamped, plus cell coords) once per frame at vsync rise.
module mouse_frame_sync
  import mouse_frame_sync_pkg::*;
#(
  parameter int H_ACTIVE   = HOR_ACTIVE,
  parameter int V_ACTIVE   = VER_ACTIVE,
  parameter int CELL_SHIFT = 4
) (
  input  logic   clk,
  input  logic   rst,
  vga_if.in      vga_in,
  input  coord_t xpos_in,
  input  coord_t ypos_in,
  input  logic   left_in,
  input  logic   right_in,
  input  logic   new_event,
  output coord_t x,
  output coord_t y,
  output coord_t cell_x,
  output coord_t cell_y,
  output logic   left_click,
  output logic   right_click,
  output logic   frame_tick
);

  typedef enum logic [1:0] {IDLE, PEND, COMMIT} state_t;

  localparam coord_t X_MAX   = coord_t'(H_ACTIVE - 1);
  localparam coord_t Y_MAX   = coord_t'(V_ACTIVE - 1);
  localparam coord_t X_RST   = coord_t'(H_ACTIVE / 2);
  localparam coord_t Y_RST   = coord_t'(V_ACTIVE / 2);
  localparam coord_t CX_RST  = coord_t'((H_ACTIVE / 2) >> CELL_SHIFT);
  localparam coord_t CY_RST  = coord_t'((V_ACTIVE / 2) >> CELL_SHIFT);

  function automatic coord_t sat_coord(input coord_t v, input coord_t lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t state_q;
  coord_t pend_x_q, pend_y_q;
  logic   lpend_q, rpend_q;
  coord_t x_q, y_q, cell_x_q, cell_y_q;
  logic   lclick_q, rclick_q, tick_q;
  coord_t x_d, y_d;
  logic   vs_rise, l_rise, r_rise;

  rise_detect u_vs_rise (.clk(clk), .rst(rst), .d_i(vga_in.vsync), .rise_o(vs_rise));
  rise_detect u_l_rise  (.clk(clk), .rst(rst), .d_i(left_in),      .rise_o(l_rise));
  rise_detect u_r_rise  (.clk(clk), .rst(rst), .d_i(right_in),     .rise_o(r_rise));

  assign x_d = sat_coord(pend_x_q, X_MAX);
  assign y_d = sat_coord(pend_y_q, Y_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_x_q <= X_RST;
      pend_y_q <= Y_RST;
      lpend_q  <= 1'b0;
      rpend_q  <= 1'b0;
      x_q      <= X_RST;
      y_q      <= Y_RST;
      cell_x_q <= CX_RST;
      cell_y_q <= CY_RST;
      lclick_q <= 1'b0;
      rclick_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      lclick_q <= 1'b0;
      rclick_q <= 1'b0;
      tick_q   <= 1'b0;
      if (new_event) begin
        pend_x_q <= xpos_in;
        pend_y_q <= ypos_in;
      end
      // A rising edge in the commit cycle survives the clear and reports next frame.
      lpend_q <= l_rise | (lpend_q & (state_q != COMMIT));
      rpend_q <= r_rise | (rpend_q & (state_q != COMMIT));
      case (state_q)
        IDLE: begin
          if (vs_rise)        state_q <= COMMIT;
          else if (new_event) state_q <= PEND;
        end
        PEND: begin
          if (vs_rise) state_q <= COMMIT;
        end
        COMMIT: begin
          x_q      <= x_d;
          y_q      <= y_d;
          cell_x_q <= x_d >> CELL_SHIFT;
          cell_y_q <= y_d >> CELL_SHIFT;
          tick_q   <= 1'b1;
          lclick_q <= lpend_q;
          rclick_q <= rpend_q;
          state_q  <= new_event ? PEND : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign cell_x      = cell_x_q;
  assign cell_y      = cell_y_q;
  assign left_click  = lclick_q;
  assign right_click = rclick_q;
  assign frame_tick  = tick_q;

endmodule

// File: doc/mouse_frame_sync.md
Name: mouse_frame_sync

Overview:
Upstream neighbour of the cursor overlay stage. Captures raw mouse reports (position, buttons) from the PS/2 mouse controller, holds them as pending, and commits them only at the start of vertical sync. This keeps the cursor position and click events stable for a whole frame. Commits are clamped to the visible area and also converted to board-cell coordinates for game logic. Outputs x/y drive the overlay stage directly.

Parameters:
H_ACTIVE, 1024, visible pixels per line; x is clamped to H_ACTIVE-1
V_ACTIVE, 768, visible lines; y is clamped to V_ACTIVE-1
CELL_SHIFT, 4, log2 of board cell size in pixels (cell = pixel >> CELL_SHIFT)

Ports:
clk  in  1  pixel clock; the only clock
rst  in  1  synchronous, active-high reset
vga_in  vga_if.in  -  timing bus; only vsync is used
xpos_in  in  12  raw mouse x from the controller
ypos_in  in  12  raw mouse y from the controller
left_in  in  1  left button level
right_in  in  1  right button level
new_event  in  1  one-cycle strobe; xpos_in/ypos_in are valid in this cycle
x  out  12  committed, clamped cursor x
y  out  12  committed, clamped cursor y
cell_x  out  12  x >> CELL_SHIFT
cell_y  out  12  y >> CELL_SHIFT
left_click  out  1  one-cycle pulse per frame if a left rising edge occurred since the last commit
right_click  out  1  same, for the right button
frame_tick  out  1  one-cycle pulse in every commit cycle, whether or not data changed

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values:
  - x = H_ACTIVE/2, y = V_ACTIVE/2, cell_x/cell_y derived from these
  - left_click, right_click, frame_tick = 0
  - FSM = IDLE; pending registers = reset x/y; click-pending flags = 0
  - vsync_q and button-history flops = 0
- Edge detection:
  - vs_rise = vga_in.vsync & ~vsync_q.
  - A button rising edge is left_in & ~left_q (right likewise).
  - All history flops are registered every cycle.
- Capture:
  - On new_event, load pend_x/pend_y from xpos_in/ypos_in in any state.
  - The last event before a commit wins.
- Click pending:
  - A rising edge sets the sticky flag.
  - A commit clears it.
  - If a rising edge and a commit happen in the same cycle, set wins: the flag stays 1 and is reported next frame.
- FSM states and transitions:
  - IDLE: on new_event go to PEND. On vs_rise with no data but a click pending, go to COMMIT. A vs_rise with nothing pending still goes to COMMIT so that frame_tick fires every frame.
  - PEND: on vs_rise go to COMMIT. A new_event in the same cycle as vs_rise is captured first, so it is included in this commit.
  - COMMIT: lasts exactly one cycle.
    - Write x = min(pend_x, H_ACTIVE-1) and y = min(pend_y, V_ACTIVE-1), both unsigned compares.
    - Write cell_x/cell_y from the clamped values.
    - Pulse frame_tick, plus left_click/right_click as their flags dictate.
    - Next state is PEND if new_event arrives during COMMIT, otherwise IDLE.
- Latency: let k be the cycle in which vs_rise = 1. COMMIT is cycle k+1, and the registered outputs show new values from cycle k+2. The pulses are high for exactly cycle k+2.
- Output holding: x/y never change outside the k+2 update, so cursor drawing is glitch-free within a frame.
- Reset mid-operation: all pending data is discarded and outputs return to the reset values on the next edge.
- Widths: all coordinates are 12-bit unsigned; no overflow is possible.

Decomposition:
- vga_pkg holds H_ACTIVE/V_ACTIVE defaults (the existing HOR/VER active constants) and a typedef for 12-bit coordinates.
- The FSM state enum (IDLE, PEND, COMMIT) is local to the module.
- One natural sub-module, rise_detect: a 1-bit registered rising-edge detector, used three times (vsync, left, right).

Test Plan:
- Reset: assert rst 2 cycles -> x=512, y=384, cell_x=32, cell_y=24, all pulses 0.
- Basic commit: new_event with (100,200), then vsync rises at cycle k -> x=100, y=200, cell_x=6, cell_y=12 from k+2; frame_tick=1 only at k+2; x/y unchanged at k, k+1.
- Clamp and last-wins: events (3000,50) then (1500,900) before vsync -> x=1023, y=767.
- Collision: new_event (10,10) in the same cycle as vs_rise from PEND holding (20,20) -> commit gives (10,10).
- Click: left rising edge mid-frame -> left_click is a single pulse at k+2 and none the next frame. A left rising edge during COMMIT -> pulse occurs the following frame.
- Idle frames: no events for 3 vsyncs -> frame_tick pulses 3 times; x/y hold; click outputs stay 0.
